// File: rtl/sprite_compositor.sv
// sprite_compositor: two-stage pixel pipeline that places an upscaled sprite
// window on a background colour, with a frame-synchronous animation swap.
//   S1: window test and texel address generation (addresses drive external RAM)
//   S2: capture of the combinational RAM texel and colour composition
// Optional colour keying is enabled by defining SPRITE_COMPOSITOR_KEY_EN.
//
// Pipeline handshake: there is no back-pressure. 'valid' marks a visible
// screen pixel on every cycle it is high, each stage carries its own valid
// bit forward, and 'pixel_valid' rises exactly two cycles after the pixel's
// 'valid'. One pixel is accepted per cycle, so no bubbles are ever inserted.
module sprite_compositor #(
    parameter int          SPR_X0      = 192,
    parameter int          SPR_Y0      = 112,
    parameter int          SCALE_SHIFT = 1,
    parameter int          SPR_SIZE    = 128,
    parameter logic [11:0] BG_COLOR    = 12'h000,
    parameter logic [11:0] KEY_COLOR   = 12'h0F0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        valid,
    input  logic [1:0]  anim_sel,
    output logic [7:0]  ram_addr_x,
    output logic [7:0]  ram_addr_y,
    input  logic [15:0] ram_data,
    output logic [1:0]  anim_active,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        pixel_valid
);

    // Window bounds held at 11 bits so the upper edge cannot wrap.
    localparam logic [10:0] X_LO = 11'(SPR_X0);
    localparam logic [10:0] X_HI = 11'(SPR_X0 + (SPR_SIZE << SCALE_SHIFT));
    localparam logic [10:0] Y_LO = 11'(SPR_Y0);
    localparam logic [10:0] Y_HI = 11'(SPR_Y0 + (SPR_SIZE << SCALE_SHIFT));

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PEND  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  anim_q, anim_d;

    logic        s1_valid_q, s1_valid_d;
    logic        s1_win_q, s1_win_d;
    logic        s1_blank_q, s1_blank_d;
    logic [7:0]  addr_x_q, addr_x_d;
    logic [7:0]  addr_y_q, addr_y_d;

    logic        pix_valid_q, pix_valid_d;
    logic [11:0] colour_q, colour_d;

    logic        frame_start;
    logic [10:0] h_ext, v_ext, dx, dy;
    logic [11:0] texel;

    // Upper RAM bits carry no colour information.
    logic unused_ram_hi;
    assign unused_ram_hi = ^ram_data[15:12];

`ifndef SPRITE_COMPOSITOR_KEY_EN
    logic unused_key;
    assign unused_key = ^KEY_COLOR;
`endif

    assign frame_start = valid && (h_cnt == 10'd0) && (v_cnt == 10'd0);
    assign texel       = ram_data[11:0];

    // Animation swap: a request is parked until frame start, then the new
    // animation is latched and its first frame is hidden behind BG_COLOR.
    always_comb begin
        state_d = state_q;
        anim_d  = anim_q;
        unique case (state_q)
            ST_RUN: begin
                if (anim_sel != anim_q) state_d = ST_PEND;
            end
            ST_PEND: begin
                if (frame_start) begin
                    if (anim_sel == anim_q) begin
                        state_d = ST_RUN;
                    end else begin
                        anim_d  = anim_sel;
                        state_d = ST_BLANK;
                    end
                end
            end
            ST_BLANK: begin
                if (frame_start) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // S1: window test and texel address. The blank decision follows the
    // next state so the frame-start pixel belongs to the frame it opens.
    always_comb begin
        h_ext      = {1'b0, h_cnt};
        v_ext      = {1'b0, v_cnt};
        dx         = h_ext - X_LO;
        dy         = v_ext - Y_LO;
        s1_valid_d = valid;
        s1_win_d   = valid && (h_ext >= X_LO) && (h_ext < X_HI)
                           && (v_ext >= Y_LO) && (v_ext < Y_HI);
        s1_blank_d = (state_d == ST_BLANK);
        addr_x_d   = 8'd0;
        addr_y_d   = 8'd0;
        if (s1_win_d) begin
            addr_x_d = 8'(dx >> SCALE_SHIFT);
            addr_y_d = 8'(dy >> SCALE_SHIFT);
        end
    end

    // S2: colour composition from the texel returned for the S1 address.
    always_comb begin
        pix_valid_d = s1_valid_q;
        colour_d    = 12'h000;
        if (s1_valid_q) begin
            if (!s1_win_q || s1_blank_q) begin
                colour_d = BG_COLOR;
            end else begin
`ifdef SPRITE_COMPOSITOR_KEY_EN
                colour_d = (texel == KEY_COLOR) ? BG_COLOR : texel;
`else
                colour_d = texel;
`endif
            end
        end
    end

    // State, animation and pipeline registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            anim_q      <= 2'd0;
            s1_valid_q  <= 1'b0;
            s1_win_q    <= 1'b0;
            s1_blank_q  <= 1'b0;
            addr_x_q    <= 8'd0;
            addr_y_q    <= 8'd0;
            pix_valid_q <= 1'b0;
            colour_q    <= 12'h000;
        end else begin
            state_q     <= state_d;
            anim_q      <= anim_d;
            s1_valid_q  <= s1_valid_d;
            s1_win_q    <= s1_win_d;
            s1_blank_q  <= s1_blank_d;
            addr_x_q    <= addr_x_d;
            addr_y_q    <= addr_y_d;
            pix_valid_q <= pix_valid_d;
            colour_q    <= colour_d;
        end
    end

    assign ram_addr_x  = addr_x_q;
    assign ram_addr_y  = addr_y_q;
    assign anim_active = anim_q;
    assign vga_r       = colour_q[11:8];
    assign vga_g       = colour_q[7:4];
    assign vga_b       = colour_q[3:0];
    assign pixel_valid = pix_valid_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor (default parameters). The reference model works
// on whole pixels: screen coordinates to texel coordinates by division, a
// texture array standing in for the external RAM, and a frame-level record of
// whether a swap is waiting or the current frame is blanked.
module tb_sprite_compositor;

    localparam int          X0   = 192;
    localparam int          Y0   = 112;
    localparam int          WIN  = 256;
    localparam logic [11:0] BG   = 12'h000;
    localparam logic [11:0] KEY  = 12'h0F0;

    logic        clk;
    logic        rst;
    logic [9:0]  h_cnt, v_cnt;
    logic        valid;
    logic [1:0]  anim_sel;
    logic [7:0]  ram_addr_x, ram_addr_y;
    logic [15:0] ram_data;
    logic [1:0]  anim_active;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        pixel_valid;

    logic [15:0] tex_mem [65536];
    logic [12:0] exp_q[$];

    int checks = 0;
    int errors = 0;

    // model state: animation shown, swap waiting, current frame blanked
    logic [1:0] m_act;
    bit         m_wait;
    bit         m_blank;

    sprite_compositor dut (
        .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid),
        .anim_sel(anim_sel), .ram_addr_x(ram_addr_x), .ram_addr_y(ram_addr_y),
        .ram_data(ram_data), .anim_active(anim_active), .vga_r(vga_r),
        .vga_g(vga_g), .vga_b(vga_b), .pixel_valid(pixel_valid)
    );

    assign ram_data = tex_mem[{anim_active, ram_addr_y[6:0], ram_addr_x[6:0]}];

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] obs_px();
        return {pixel_valid, vga_r, vga_g, vga_b};
    endfunction

    function automatic logic [15:0] obs_addr();
        return {ram_addr_x, ram_addr_y};
    endfunction

    // Reference model for one input pixel: updates the frame-level swap
    // record and returns the expected composed pixel and texel address.
    task automatic model_step(input logic v, input logic [9:0] h, input logic [9:0] vv,
                              input logic [1:0] sel, output logic [12:0] px,
                              output logic [15:0] addr);
        bit   fs;
        bit   win;
        int   hi, vi, ax, ay;
        logic [6:0] ax7, ay7;
        logic [11:0] t;
        fs = v && h == 0 && vv == 0;
        if (fs && m_blank) begin
            m_blank = 0;
        end else if (fs && m_wait) begin
            m_wait = 0;
            if (sel != m_act) begin
                m_act   = sel;
                m_blank = 1;
            end
        end else if (!m_wait && !m_blank && sel != m_act) begin
            m_wait = 1;
        end
        hi  = int'(h);
        vi  = int'(vv);
        win = v && hi >= X0 && hi < X0 + WIN && vi >= Y0 && vi < Y0 + WIN;
        ax  = win ? (hi - X0) / 2 : 0;
        ay  = win ? (vi - Y0) / 2 : 0;
        ax7 = ax[6:0];
        ay7 = ay[6:0];
        addr = {ax[7:0], ay[7:0]};
        if (!v) begin
            px = 13'h0;
        end else if (!win || m_blank) begin
            px = {1'b1, BG};
        end else begin
            t = tex_mem[{m_act, ay7, ax7}][11:0];
`ifdef SPRITE_COMPOSITOR_KEY_EN
            if (t == KEY) t = BG;
`endif
            px = {1'b1, t};
        end
    endtask

    // driver: apply one pixel, advance one clock; returns the expected
    // address of this pixel and the expected output of the previous one
    task automatic drive_px(input logic v, input logic [9:0] h, input logic [9:0] vv,
                            input logic [1:0] sel, output logic [15:0] ea,
                            output logic [12:0] ep);
        logic [12:0] px;
        valid    = v;
        h_cnt    = h;
        v_cnt    = vv;
        anim_sel = sel;
        model_step(v, h, vv, sel, px, ea);
        exp_q.push_back(px);
        @(posedge clk);
        #1;
        ep = exp_q.pop_front();
    endtask

    task automatic model_reset();
        m_act   = 2'd0;
        m_wait  = 0;
        m_blank = 0;
        exp_q   = {};
        exp_q.push_back(13'h0);
    endtask

    task automatic test_reset();
        rst = 1'b0; valid = 1'b1; h_cnt = 10'd200; v_cnt = 10'd120; anim_sel = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs_px() !== 13'h0 || obs_addr() !== 16'h0 || anim_active !== 2'd0) begin
            errors++;
            $display("FAIL reset_state got px=%h addr=%h anim=%0d exp 0", obs_px(), obs_addr(), anim_active);
        end
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_corner();
        logic [15:0] ea; logic [12:0] ep;
        tex_mem[16'h0000] = 16'h0ABC;
        drive_px(1'b1, 10'd192, 10'd112, 2'd0, ea, ep);
        checks++;
        if (obs_addr() !== 16'h0000 || ea !== 16'h0000) begin
            errors++;
            $display("FAIL corner_addr got %h exp %h", obs_addr(), 16'h0000);
        end
        drive_px(1'b0, 10'd0, 10'd0, 2'd0, ea, ep);
        checks++;
        if (obs_px() !== {1'b1, 12'hABC} || ep !== {1'b1, 12'hABC}) begin
            errors++;
            $display("FAIL corner_px got %h exp %h", obs_px(), {1'b1, 12'hABC});
        end
    endtask

    task automatic test_scaling();
        logic [15:0] ea; logic [12:0] ep;
        logic [9:0]  hs [4] = '{10'd193, 10'd194, 10'd447, 10'd448};
        logic [7:0]  ax [4] = '{8'd0, 8'd1, 8'd127, 8'd0};
        for (int i = 0; i < 4; i++) begin
            drive_px(1'b1, hs[i], 10'd112, 2'd0, ea, ep);
            checks++;
            if (ram_addr_x !== ax[i] || obs_addr() !== ea) begin
                errors++;
                $display("FAIL scale_addr h=%0d got %h exp x=%h model %h", hs[i], obs_addr(), ax[i], ea);
            end
            if (i > 0) begin
                checks++;
                if (obs_px() !== ep) begin
                    errors++;
                    $display("FAIL scale_px h=%0d got %h exp %h", hs[i-1], obs_px(), ep);
                end
            end
        end
        drive_px(1'b0, 10'd0, 10'd0, 2'd0, ea, ep);
        checks++;
        if (obs_px() !== {1'b1, BG} || ep !== {1'b1, BG}) begin
            errors++;
            $display("FAIL scale_edge_bg got %h exp %h", obs_px(), {1'b1, BG});
        end
    endtask

    task automatic test_keying();
        logic [15:0] ea; logic [12:0] ep; logic [12:0] want;
        tex_mem[{2'd0, 7'd5, 7'd5}] = 16'hF0F0;
`ifdef SPRITE_COMPOSITOR_KEY_EN
        want = {1'b1, BG};
`else
        want = {1'b1, 12'h0F0};
`endif
        drive_px(1'b1, 10'd202, 10'd122, 2'd0, ea, ep);
        drive_px(1'b0, 10'd0, 10'd0, 2'd0, ea, ep);
        checks++;
        if (obs_px() !== want || ep !== want) begin
            errors++;
            $display("FAIL keying got %h exp %h", obs_px(), want);
        end
    endtask

    task automatic test_random_pixels();
        logic [15:0] ea; logic [12:0] ep;
        for (int i = 0; i < 300; i++) begin
            drive_px(($urandom_range(0, 4) != 0), 10'($urandom_range(150, 500)),
                     10'($urandom_range(90, 400)), 2'd0, ea, ep);
            checks++;
            if (obs_px() !== ep || obs_addr() !== ea) begin
                errors++;
                $display("FAIL random_px step=%0d got px=%h addr=%h exp px=%h addr=%h", i, obs_px(), obs_addr(), ep, ea);
            end
        end
    endtask

    task automatic test_swap();
        logic [15:0] ea; logic [12:0] ep;
        for (int i = 0; i < 10; i++) begin
            drive_px(1'b1, 10'($urandom_range(192, 447)), 10'($urandom_range(112, 367)), 2'd2, ea, ep);
            checks++;
            if (anim_active !== 2'd0 || obs_px() !== ep) begin
                errors++;
                $display("FAIL swap_hold got anim=%0d px=%h exp anim=0 px=%h", anim_active, obs_px(), ep);
            end
        end
        drive_px(1'b1, 10'd0, 10'd0, 2'd2, ea, ep);
        checks++;
        if (anim_active !== 2'd2 || m_act !== 2'd2) begin
            errors++;
            $display("FAIL swap_load got %0d exp 2", anim_active);
        end
        for (int i = 0; i < 40; i++) begin
            drive_px(1'b1, 10'($urandom_range(192, 447)), 10'($urandom_range(112, 367)), 2'd2, ea, ep);
            checks++;
            if (obs_px() !== {1'b1, BG} || ep !== {1'b1, BG}) begin
                errors++;
                $display("FAIL swap_blank step=%0d got %h exp %h", i, obs_px(), {1'b1, BG});
            end
        end
        tex_mem[{2'd2, 7'd10, 7'd20}] = 16'h1234;
        drive_px(1'b1, 10'd0, 10'd0, 2'd2, ea, ep);
        drive_px(1'b1, 10'd232, 10'd132, 2'd2, ea, ep);
        drive_px(1'b0, 10'd0, 10'd0, 2'd2, ea, ep);
        checks++;
        if (obs_px() !== {1'b1, 12'h234} || ep !== {1'b1, 12'h234}) begin
            errors++;
            $display("FAIL swap_show got %h exp %h", obs_px(), {1'b1, 12'h234});
        end
    endtask

    task automatic test_cancel();
        logic [15:0] ea; logic [12:0] ep;
        tex_mem[{2'd2, 7'd3, 7'd4}] = 16'h0567;
        for (int i = 0; i < 6; i++) drive_px(1'b1, 10'd300, 10'd200, 2'd1, ea, ep);
        for (int i = 0; i < 6; i++) drive_px(1'b1, 10'd300, 10'd200, 2'd2, ea, ep);
        drive_px(1'b1, 10'd0, 10'd0, 2'd2, ea, ep);
        checks++;
        if (anim_active !== 2'd2) begin
            errors++;
            $display("FAIL cancel_anim got %0d exp 2", anim_active);
        end
        drive_px(1'b1, 10'd200, 10'd118, 2'd2, ea, ep);
        drive_px(1'b0, 10'd0, 10'd0, 2'd2, ea, ep);
        checks++;
        if (obs_px() !== {1'b1, 12'h567} || ep !== {1'b1, 12'h567}) begin
            errors++;
            $display("FAIL cancel_no_blank got %h exp %h", obs_px(), {1'b1, 12'h567});
        end
    endtask

    task automatic test_random_frames();
        logic [15:0] ea; logic [12:0] ep; logic [1:0] sel;
        sel = 2'd2;
        for (int f = 0; f < 15; f++) begin
            drive_px(1'b1, 10'd0, 10'd0, sel, ea, ep);
            checks++;
            if (anim_active !== m_act || obs_px() !== ep) begin
                errors++;
                $display("FAIL frame_start f=%0d got anim=%0d px=%h exp anim=%0d px=%h", f, anim_active, obs_px(), m_act, ep);
            end
            for (int i = 0; i < 40; i++) begin
                if ($urandom_range(0, 19) == 0) sel = 2'($urandom_range(0, 3));
                drive_px(($urandom_range(0, 5) != 0), 10'($urandom_range(180, 460)),
                         10'($urandom_range(100, 380)), sel, ea, ep);
                checks++;
                if (obs_px() !== ep || obs_addr() !== ea || anim_active !== m_act) begin
                    errors++;
                    $display("FAIL frame_px f=%0d i=%0d got px=%h addr=%h anim=%0d exp px=%h addr=%h anim=%0d",
                             f, i, obs_px(), obs_addr(), anim_active, ep, ea, m_act);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] ea; logic [12:0] ep;
        for (int i = 0; i < 4; i++) drive_px(1'b1, 10'd260, 10'd150, 2'd1, ea, ep);
        drive_px(1'b1, 10'd0, 10'd0, 2'd1, ea, ep);
        for (int i = 0; i < 4; i++) drive_px(1'b1, 10'd270, 10'd160, 2'd1, ea, ep);
        rst = 1'b0;
        valid = 1'b1; h_cnt = 10'd280; v_cnt = 10'd170;
        @(posedge clk);
        #1;
        checks++;
        if (obs_px() !== 13'h0 || obs_addr() !== 16'h0 || anim_active !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid got px=%h addr=%h anim=%0d exp 0", obs_px(), obs_addr(), anim_active);
        end
        rst = 1'b1;
        model_reset();
        drive_px(1'b1, 10'd290, 10'd180, 2'd0, ea, ep);
        checks++;
        if (pixel_valid !== 1'b0 || obs_px() !== ep) begin
            errors++;
            $display("FAIL reset_resume1 got %h exp %h", obs_px(), ep);
        end
        drive_px(1'b1, 10'd291, 10'd180, 2'd0, ea, ep);
        checks++;
        if (pixel_valid !== 1'b1 || obs_px() !== ep) begin
            errors++;
            $display("FAIL reset_resume2 got %h exp %h", obs_px(), ep);
        end
    endtask

    initial begin
        rst = 1'b0; valid = 1'b0; h_cnt = 10'd0; v_cnt = 10'd0; anim_sel = 2'd0;
        for (int i = 0; i < 65536; i++) begin
            tex_mem[i] = 16'($urandom());
            if ($urandom_range(0, 7) == 0) tex_mem[i] = {tex_mem[i][15:12], KEY};
        end
        m_act = 2'd0; m_wait = 0; m_blank = 0;
        test_reset();
        test_corner();
        test_scaling();
        test_keying();
        test_random_pixels();
        test_swap();
        test_cancel();
        test_random_frames();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_compositor.md
SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 SHALL have parameter SPR_X0, default 192: left edge of the sprite window in screen pixels.
REQ-002 SHALL have parameter SPR_Y0, default 112: top edge of the sprite window in screen pixels.
REQ-003 SHALL have parameter SCALE_SHIFT, default 1: upscale factor is 2^SCALE_SHIFT; legal values are 0 and 1.
REQ-004 SHALL have parameter SPR_SIZE, default 128: sprite width and height in source texels.
REQ-005 SHALL have parameter BG_COLOR, default 12'h000: background RGB444 colour.
REQ-006 SHALL have parameter KEY_COLOR, default 12'h0F0: transparent RGB444 colour.
REQ-007 SHALL have port clk, input, width 1: single clock for the whole block.
REQ-008 SHALL have port rst, input, width 1: reset, synchronous and active-low.
REQ-009 SHALL have port h_cnt, input, width 10: current horizontal screen pixel.
REQ-010 SHALL have port v_cnt, input, width 10: current vertical screen line.
REQ-011 SHALL have port valid, input, width 1: high while the screen is in the visible area.
REQ-012 SHALL have port anim_sel, input, width 2: requested animation.
REQ-013 SHALL have port ram_addr_x, output, width 8: sprite texel column.
REQ-014 SHALL have port ram_addr_y, output, width 8: sprite texel row.
REQ-015 SHALL have port ram_data, input, width 16: texel data, combinational from the addresses; bits [11:0] are RGB444 and bits [15:12] are ignored.
REQ-016 SHALL have port anim_active, output, width 2: the latched animation, which drives the external memory mux.
REQ-017 SHALL have ports vga_r, vga_g and vga_b, output, width 4 each.
REQ-018 SHALL have port pixel_valid, output, width 1: the composited pixel on the vga outputs is valid.

Function
REQ-019 SHALL run a 2-stage pipeline.
- S1 registers the addresses and the in-window flag from h_cnt, v_cnt and valid.
- S2 registers ram_data, then composes the colour into vga_r/g/b.
- Output latency from valid is exactly 2 cycles.
REQ-020 SHALL compute the in-window flag as true when SPR_X0 <= h_cnt < SPR_X0 + (SPR_SIZE << SCALE_SHIFT), and likewise for v_cnt against SPR_Y0.
- Both comparisons SHALL be done at 11-bit width so they cannot wrap.
REQ-021 SHALL set ram_addr_x = (h_cnt - SPR_X0) >> SCALE_SHIFT, truncated to 8 bits, and compute ram_addr_y likewise from v_cnt and SPR_Y0.
REQ-022 SHALL drive ram_addr_x and ram_addr_y to 0 when the pixel is out of the window.
REQ-023 SHALL output BG_COLOR for a pixel that is out of the window but valid.
REQ-024 SHALL output 12'h000 with pixel_valid=0 when the delayed valid is low.
REQ-025 SHALL define frame start as the cycle in which valid=1, h_cnt=0 and v_cnt=0.
REQ-026 SHALL implement an animation-swap FSM with states RUN, PEND and BLANK.
- RUN: when anim_sel != anim_active, go to PEND.
- PEND at frame start: if anim_sel == anim_active, go to RUN; otherwise load anim_active <= anim_sel and go to BLANK.
- PEND with no frame start: hold.
- BLANK: output BG_COLOR for every in-window pixel for one whole frame; at the next frame start, go to RUN.
REQ-027 SHALL change anim_active only at a frame start, never mid-frame.
REQ-028 SHALL leave the FSM in BLANK when anim_sel changes during BLANK; the new request is handled from RUN.
REQ-029 SHALL insert no bubbles: the pipeline accepts one pixel every cycle.

Reset
REQ-030 SHALL, while rst=0 on a clk edge, clear anim_active, the pipeline stage-valid bits, ram_addr_x/y, vga_r/g/b and pixel_valid to 0, and set the state to RUN.
REQ-031 SHALL, on reset mid-frame, discard the in-flight pixels, with the first output valid 2 cycles after the first post-reset valid.

Configuration
REQ-032 SHALL implement colour keying under macro SPRITE_COMPOSITOR_KEY_EN.
- When defined, in-window texels equal to KEY_COLOR are output as BG_COLOR.
- When undefined, all in-window texels are output unmodified, KEY_COLOR included.

Verification
REQ-033 SHALL test the window corner: valid=1, h=192, v=112, ram_data=16'h0ABC gives addr (0,0); 2 cycles later, RGB=A,B,C and pixel_valid=1.
REQ-034 SHALL test scaling: h=193 and h=194 with v=112 give ram_addr_x=0 and 1 respectively; h=447 gives 127; h=448 gives BG 000.
REQ-035 SHALL test keying: ram_data=16'hF0F0 in-window gives 000 (BG) with the macro defined, and RGB=0,F,0 without the macro.
REQ-036 SHALL test the swap: anim_sel 0->2 mid-frame keeps anim_active=0 until frame start, then anim_active=2; the next frame is entirely BG, and the frame after shows sprite pixels.
REQ-037 SHALL test the PEND cancel: anim_sel 0->1->0 before frame start gives FSM back to RUN, anim_active stays 0, and no blank frame.
REQ-038 SHALL test reset: rst=0 asserted for 1 cycle mid-window gives all outputs 0 on the next cycle; valid pixels resume 2 cycles after rst=1.
